// File: rtl/pixel_pkg.sv
// Shared types for the pixel readout block: FSM state encoding and the
// default {row, col, data} word carried through the output FIFO.
package pixel_pkg;

   localparam int PIX_DATA_W = 8;
   localparam int PIX_N_COL  = 2;
   localparam int PIX_COL_W  = (PIX_N_COL > 1) ? $clog2(PIX_N_COL) : 1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETTLE   = 2'd1,
      ST_PUSH     = 2'd2,
      ST_WAIT_LOW = 2'd3
   } rdo_state_t;

   typedef struct packed {
      logic                  row;
      logic [PIX_COL_W-1:0]  col;
      logic [PIX_DATA_W-1:0] data;
   } pixel_word_t;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead synchronous FIFO of pixel words. A push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module pixel_fifo
   import pixel_pkg::*;
#(
   parameter int  DEPTH  = 4,
   parameter type word_t = pixel_word_t
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  i_push,
   input  word_t i_wdata,
   input  logic  i_pop,
   output word_t o_rdata,
   output logic  o_full,
   output logic  o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   word_t             r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_pop;
   logic              w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pixel_readout.sv
// Row readout: watches read1/read2, samples the settled ADC bus, and streams
// per-pixel {row, col, data} words through a small FIFO with valid/ready.
//
// state       | meaning
// ST_IDLE     | waiting for a fresh read1/read2 rising edge
// ST_SETTLE   | strobe high, counting settle cycles before sampling the bus
// ST_PUSH     | pushing one captured column per cycle into the FIFO
// ST_WAIT_LOW | row done or protocol error; waiting for both strobes low
module pixel_readout
   import pixel_pkg::*;
#(
   parameter int DATA_W     = PIX_DATA_W,
   parameter int N_COL      = PIX_N_COL,
   parameter int SETTLE     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      read1,
   input  logic                      read2,
   input  logic [N_COL*DATA_W-1:0]   pix_data,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_row,
   output logic [$clog2(N_COL)-1:0]  out_col,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      frame_done,
   output logic                      overflow,
   output logic                      rd_err
);

   localparam int COL_W = $clog2(N_COL);
   localparam int CNT_W = $clog2(SETTLE) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COL - 1);

   typedef struct packed {
      logic              row;
      logic [COL_W-1:0]  col;
      logic [DATA_W-1:0] data;
   } word_t;

   rdo_state_t              r_state;
   logic                    r_rd1_q;
   logic                    r_rd2_q;
   logic                    r_row;
   logic [CNT_W-1:0]        r_cnt;
   logic [COL_W-1:0]        r_col;
   logic [N_COL*DATA_W-1:0] r_cap;
   logic                    r_frame_ok;
   logic                    r_frame_done;
   logic                    r_overflow;
   logic                    r_rd_err;

   logic                    w_rise1;
   logic                    w_rise2;
   logic                    w_active;
   logic                    w_other_rise;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_drop;
   logic [DATA_W-1:0]       w_pix;
   word_t                   w_wdata;
   word_t                   w_head;

   assign w_rise1      = read1 & ~r_rd1_q;
   assign w_rise2      = read2 & ~r_rd2_q;
   assign w_active     = r_row ? read2 : read1;
   assign w_other_rise = r_row ? w_rise1 : w_rise2;

   always_comb begin
      w_pix = '0;
      for (int c = 0; c < N_COL; c++) begin
         if (r_col == COL_W'(c)) begin
            w_pix = r_cap[c*DATA_W +: DATA_W];
         end
      end
   end

   assign w_push  = (r_state == ST_PUSH);
   assign w_wdata = {r_row, r_col, w_pix};
   assign w_pop   = ~w_empty & out_ready;
   assign w_drop  = w_push & w_full & ~w_pop;

   pixel_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .word_t (word_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_wdata (w_wdata),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_rd1_q      <= 1'b0;
         r_rd2_q      <= 1'b0;
         r_row        <= 1'b0;
         r_cnt        <= '0;
         r_col        <= '0;
         r_cap        <= '0;
         r_frame_ok   <= 1'b0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
         r_rd_err     <= 1'b0;
      end else begin
         r_rd1_q      <= read1;
         r_rd2_q      <= read2;
         r_frame_done <= 1'b0;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (read1 && read2) begin
                  r_rd_err <= 1'b1;
                  r_state  <= ST_WAIT_LOW;
               end else if (w_rise1) begin
                  // read1 opens a new frame and clears the sticky flags
                  r_row      <= 1'b0;
                  r_cnt      <= '0;
                  r_overflow <= 1'b0;
                  r_rd_err   <= 1'b0;
                  r_frame_ok <= 1'b0;
                  r_state    <= ST_SETTLE;
               end else if (w_rise2) begin
                  r_row   <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (!w_active || w_other_rise) begin
                  r_rd_err <= 1'b1;
                  r_state  <= ST_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_cap   <= pix_data;
                  r_col   <= '0;
                  r_state <= ST_PUSH;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_PUSH: begin
               if (r_col == COL_LAST) begin
                  if (!r_row) begin
                     r_frame_ok <= 1'b1;
                  end else if (r_frame_ok) begin
                     r_frame_done <= 1'b1;
                  end else begin
                     r_rd_err <= 1'b1;
                  end
                  r_state <= ST_WAIT_LOW;
               end else begin
                  r_col <= r_col + 1'b1;
               end
            end
            ST_WAIT_LOW: begin
               if (!read1 && !read2) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_data   = w_head.data;
   assign out_row    = w_head.row;
   assign out_col    = w_head.col;
   assign out_valid  = ~w_empty;
   assign frame_done = r_frame_done;
   assign overflow   = r_overflow;
   assign rd_err     = r_rd_err;

endmodule

// File: tb/tb_pixel_readout.sv
// Bench for pixel_readout: an offset-based behavioural model of the row
// readout plus a queue FIFO, checked every cycle, with literal word checks.
module tb_pixel_readout;

   localparam int DATA_W = 8;
   localparam int N_COL  = 2;
   localparam int SETTLE = 2;
   localparam int DEPTH  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        read1 = 1'b0;
   logic        read2 = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] pix_data = '0;
   logic [7:0]  out_data;
   logic        out_row;
   logic [0:0]  out_col;
   logic        out_valid;
   logic        frame_done;
   logic        overflow;
   logic        rd_err;

   always #5 clk = ~clk;

   pixel_readout #(
      .DATA_W     (DATA_W),
      .N_COL      (N_COL),
      .SETTLE     (SETTLE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .read1      (read1),
      .read2      (read2),
      .pix_data   (pix_data),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_col    (out_col),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .overflow   (overflow),
      .rd_err     (rd_err)
   );

   typedef struct {
      logic       row;
      int         col;
      logic [7:0] data;
   } wd_t;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc = 0;
   int  raise_cyc = 0;
   int  fd_cnt = 0;
   int  first_valid_cyc = -1;

   // model state: a read in progress is described by its start edge t0
   wd_t        mq[$];
   wd_t        xq[$];
   bit         p1, p2, active, waitlow, fok, arow;
   bit         e_fd, e_ovf, e_err;
   int         t0;
   logic [15:0] mcap;
   bit         s_valid;
   wd_t        s_word;

   logic [9:0] exp_nom [4] = '{10'h011, 10'h122, 10'h233, 10'h344};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      active = 0; waitlow = 0; fok = 0; arow = 0;
      e_fd = 0; e_ovf = 0; e_err = 0;
      p1 = 0; p2 = 0; mcap = '0;
   endtask

   task automatic model_step();
      bit  r1, r2, ri1, ri2, push, pop;
      int  k;
      wd_t w;
      r1 = read1; r2 = read2;
      ri1 = r1 && !p1; ri2 = r2 && !p2;
      push = 0;
      w = '{1'b0, 0, 8'h00};
      if (s_valid && out_ready) xq.push_back(s_word);
      e_fd = 0;
      if (waitlow) begin
         if (!r1 && !r2) waitlow = 0;
      end else if (active) begin
         k = cyc - t0;
         if (k <= SETTLE) begin
            if (!(arow ? r2 : r1) || (arow ? ri1 : ri2)) begin
               e_err = 1; active = 0;
            end else if (k == SETTLE) begin
               mcap = pix_data;
            end
         end else begin
            w.row = arow; w.col = k - SETTLE - 1; w.data = mcap[w.col*8 +: 8];
            push = 1;
            if (w.col == N_COL - 1) begin
               if (!arow) fok = 1;
               else if (fok) e_fd = 1;
               else e_err = 1;
               active = 0; waitlow = 1;
            end
         end
      end else begin
         if (r1 && r2) begin
            e_err = 1; waitlow = 1;
         end else if (ri1) begin
            active = 1; arow = 0; t0 = cyc; e_ovf = 0; e_err = 0; fok = 0;
         end else if (ri2) begin
            active = 1; arow = 1; t0 = cyc;
         end
      end
      pop = (mq.size() > 0) && out_ready;
      if (push && !(mq.size() < DEPTH || pop)) begin
         e_ovf = 1; push = 0;
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(w);
      p1 = r1; p2 = r2;
   endtask

   always @(posedge clk) begin
      cyc++;
      if (!reset) model_clear();
      else model_step();
      #1;
      if (!reset) begin
         chk("reset_state", {out_valid, out_data, out_row, out_col, frame_done, overflow, rd_err}, '0);
      end else begin
         chk("out_valid", out_valid, mq.size() != 0);
         if (mq.size() > 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_row", out_row, mq[0].row);
            chk("out_col", out_col, mq[0].col);
         end
         chk("frame_done", frame_done, e_fd);
         chk("overflow", overflow, e_ovf);
         chk("rd_err", rd_err, e_err);
      end
      s_valid = out_valid;
      s_word  = '{out_row, int'(out_col), out_data};
      if (frame_done) fd_cnt++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
   end

   task automatic strobe(input bit row, input int n, input logic [15:0] bus);
      @(negedge clk);
      pix_data = bus;
      if (row) read2 = 1'b1;
      else read1 = 1'b1;
      raise_cyc = cyc + 1;
      repeat (n) @(negedge clk);
      read1 = 1'b0;
      read2 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_nominal_words(input string nm);
      chk({nm, "_count"}, xq.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < xq.size())
            chk(nm, {xq[i].row, 1'(xq[i].col), xq[i].data}, exp_nom[i]);
      end
   endtask

   initial begin
      int r1c;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // nominal frame
      out_ready = 1'b1; xq.delete(); fd_cnt = 0;
      strobe(0, 5, 16'h2211);
      r1c = raise_cyc;
      strobe(1, 5, 16'h4433);
      repeat (3) @(negedge clk);
      chk_nominal_words("nom_word");
      chk("nom_frame_done", fd_cnt, 1);
      chk("nom_latency", first_valid_cyc - r1c, 3);
      chk("nom_flags", {overflow, rd_err}, 2'b00);

      // backpressure across two frames
      out_ready = 1'b0; xq.delete();
      strobe(0, 5, 16'h2211);
      strobe(1, 5, 16'h4433);
      strobe(0, 5, 16'h6655);
      strobe(1, 5, 16'h8877);
      chk("bp_overflow", overflow, 1);
      chk("bp_no_xfer", xq.size(), 0);
      out_ready = 1'b1;
      repeat (8) @(negedge clk);
      chk_nominal_words("bp_word");

      // short strobe, then a clean read1 clears the error
      xq.delete();
      strobe(0, 1, 16'hAAAA);
      chk("short_err", rd_err, 1);
      chk("short_empty", {out_valid, 32'(xq.size())}, '0);
      strobe(0, 5, 16'h5A5A);
      chk("short_clear", {rd_err, overflow}, 2'b00);

      // simultaneous strobes
      xq.delete();
      @(negedge clk);
      read1 = 1'b1; read2 = 1'b1;
      repeat (5) @(negedge clk);
      read1 = 1'b0; read2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("sim_err", rd_err, 1);
      chk("sim_no_words", xq.size(), 0);
      strobe(0, 5, 16'h1234);
      repeat (2) @(negedge clk);
      chk("sim_recover_words", xq.size(), 2);
      chk("sim_recover_err", rd_err, 0);

      // orphan read2 after reset
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      xq.delete(); fd_cnt = 0;
      strobe(1, 5, 16'hBBCC);
      repeat (2) @(negedge clk);
      chk("orph_count", xq.size(), 2);
      if (xq.size() > 1) begin
         chk("orph_word0", {xq[0].row, 1'(xq[0].col), xq[0].data}, 10'h2CC);
         chk("orph_word1", {xq[1].row, 1'(xq[1].col), xq[1].data}, 10'h3BB);
      end
      chk("orph_frame_done", fd_cnt, 0);
      chk("orph_err", rd_err, 1);

      // reset while pushing
      out_ready = 1'b0;
      @(negedge clk);
      pix_data = 16'h9988; read1 = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_pre_valid", out_valid, 1);
      reset = 1'b0; read1 = 1'b0;
      #1;
      chk("rst_outputs", {out_valid, out_data, out_row, out_col, frame_done, overflow, rd_err}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      out_ready = 1'b1; xq.delete(); fd_cnt = 0;
      strobe(0, 5, 16'h2211);
      strobe(1, 5, 16'h4433);
      repeat (3) @(negedge clk);
      chk_nominal_words("post_rst_word");
      chk("post_rst_frame_done", fd_cnt, 1);
      chk("post_rst_err", rd_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pixel_readout.md
# pixel_readout

Receive side of the pixel control sequence: watches the `read1`/`read2` strobes produced by the pixel state machine and samples the pixel array's parallel ADC output bus for each row once it has settled. It serialises each row into per-pixel words in a small FIFO and streams them out with a valid/ready handshake. It also reports frame completion and protocol or overflow errors. It sits between the pixel array and the downstream image sink.

## Interface
- `DATA_W`, 8: ADC word width per pixel.
- `N_COL`, 2: pixels per row on the bus.
- `SETTLE`, 2: cycles a read strobe must be high before the bus is sampled (≥1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-low: asserted when 0.
- `read1`  in  1  row-0 read strobe from pixel state machine.
- `read2`  in  1  row-1 read strobe.
- `pix_data`  in  N_COL*DATA_W  ADC bus; column c occupies bits [c*DATA_W +: DATA_W].
- `out_data`  out  DATA_W  FIFO head pixel value.
- `out_row`  out  1  row of head word (0 = read1, 1 = read2).
- `out_col`  out  $clog2(N_COL)  column of head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  sink accepts; transfer on `out_valid && out_ready`.
- `frame_done`  out  1  one-cycle pulse after the last row-1 word is pushed.
- `overflow`  out  1  sticky; a word was dropped due to a full FIFO.
- `rd_err`  out  1  sticky; protocol violation seen.

## Operation
- Strobes are registered once per cycle. A rising edge is a sampled 1 with the previous sample 0.
- States: IDLE, SETTLE, PUSH, WAIT_LOW.
- IDLE:
  - `read1` rising: row←0, cnt←0, clear `overflow` and `rd_err`, frame_ok←0, go to SETTLE.
  - `read2` rising: row←1, cnt←0, go to SETTLE.
  - Both rising, or both high, in the same cycle: set `rd_err`, go to WAIT_LOW, no capture.
- SETTLE:
  - Each cycle cnt++.
  - Active strobe drops, or the other strobe rises, before cnt reaches SETTLE: set `rd_err`, go to IDLE, nothing pushed.
  - cnt == SETTLE-1 with the strobe still high: latch `pix_data` into the capture register, col←0, go to PUSH.
- PUSH:
  - One word per cycle, col 0..N_COL-1, each tagged {row, col}.
  - After col N_COL-1: if row==0, set frame_ok←1. If row==1 and frame_ok, pulse `frame_done`; if row==1 and !frame_ok, set `rd_err`. Go to WAIT_LOW.
  - PUSH completes even if the strobe drops mid-push.
- WAIT_LOW: go to IDLE once both strobes are sampled 0.
- FIFO:
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - Pop on empty is impossible (`out_valid` = 0).
- Reset mid-operation: FIFO emptied, state→IDLE, frame_ok←0, capture register cleared.

## Timing
- Reset values: `out_data`=0, `out_row`=0, `out_col`=0, `out_valid`=0, `frame_done`=0, `overflow`=0, `rd_err`=0.
- Let E0 be the edge at which the rising strobe is first sampled.
  - Bus is sampled at edge E(SETTLE).
  - Column c is pushed at edge E(SETTLE+1+c).
  - `out_valid` rises in the cycle after E(SETTLE+1), if the FIFO was empty.
- `frame_done` is high for exactly the cycle following edge E(SETTLE+N_COL) of the row-1 read.
- FIFO is show-ahead: `out_data`, `out_row` and `out_col` are stable while `out_valid` is high and `out_ready` is low. The next head is presented the cycle after a transfer.
- Pixel state machine strobes change on negedge; this block samples only on posedge. No combinational path from inputs to outputs.

## Structure
- `pixel_pkg`: `rdo_state_t` enum (IDLE, SETTLE, PUSH, WAIT_LOW), default `DATA_W`/`N_COL` constants, and a packed word struct {row, col, data}.
- Sub-module `pixel_fifo`: synchronous FIFO of the packed struct with push/pop/full/empty/count. Top level holds the FSM, edge detect, capture register and sticky flags.

## Test plan
- Nominal frame, defaults: `read1` high 5 cycles with bus {0x22,0x11}, then `read2` high 5 cycles with bus {0x44,0x33}, `out_ready`=1 → words (0,0,0x11),(0,1,0x22),(1,0,0x33),(1,1,0x44) in order, one `frame_done` pulse, no flags.
- Backpressure: `out_ready`=0 across two frames (8 words, FIFO_DEPTH=4) → first 4 words held stable, `overflow`=1; after `out_ready`=1 exactly those 4 words drain.
- Short strobe: `read1` high for 1 cycle → nothing pushed, `rd_err`=1. The next `read1` rising clears `rd_err`.
- Simultaneous strobes: `read1` and `read2` rise on the same edge → `rd_err`=1, no words, FSM returns to IDLE after both go low.
- Orphan `read2`: `read2` without a prior `read1` after reset → two row-1 words pushed, no `frame_done`, `rd_err`=1.
- Reset during PUSH: `reset`=0 after the first word is pushed → `out_valid`=0, all outputs at reset values. A subsequent nominal frame is correct.
